nibble_add_seq: RTL and testbench



---
 rtl/nibble_seq_pkg.sv | 15 +
 rtl/add4_core.sv | 25 ++
 rtl/nibble_add_seq.sv | 151 +++++++++++++++
 tb/tb_nibble_add_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encodings and
// the width of the shared adder core.
package nibble_seq_pkg;

    // Width of the single adder core; operands are walked through it in
    // slices of this size, least significant slice first.
    localparam int NIBBLE = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage : nibble_seq_pkg

// File: rtl/add4_core.sv
// Purely combinational 4-bit ripple-carry adder built from 1-bit
// full-adder cells. One instance is time-shared across all nibbles.
module add4_core
    import nibble_seq_pkg::*;
(
    input  logic [NIBBLE-1:0] a4,
    input  logic [NIBBLE-1:0] b4,
    input  logic              ci,
    output logic [NIBBLE-1:0] s4,
    output logic              co
);

    // Ripple chain: c[i] is the carry into cell i, c[NIBBLE] leaves the core.
    logic [NIBBLE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
        assign s4[i]  = a4[i] ^ b4[i] ^ c[i];
        assign c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
    end

    assign co = c[NIBBLE];

endmodule : add4_core

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder that sequences one shared 4-bit adder core
// over the operands, one nibble per clock, least significant first.
// Handshake: start (accepted in IDLE or DONE) / busy (RUN) / done (pulse).
// Optional feature: define NIBBLE_SEQ_SUB_EN to add the sub port, which
// turns the operation into a - b (c_out = 1 means no borrow).
module nibble_add_seq
    import nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NIBBLE_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIB   = WIDTH / NIBBLE;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic              c_out_q;

    logic              accept;
    logic              last_nib;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

    logic [NIBBLE-1:0] a_nib;
    logic [NIBBLE-1:0] b_nib;
    logic [NIBBLE-1:0] s_nib;
    logic              co_nib;

    // A new request is only taken when no operation is in flight.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_nib = (idx_q == IDX_LAST);

`ifdef NIBBLE_SEQ_SUB_EN
    // Subtraction as a + ~b + 1: invert B at capture and force the carry in.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE/DONE -> RUN on start, RUN -> DONE after the last nibble.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_nib) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state, so done and busy
    // can never be high together.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Select the current nibble of each captured operand for the shared core.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_nib = a_q[k*NIBBLE +: NIBBLE];
                b_nib = b_q[k*NIBBLE +: NIBBLE];
            end
        end
    end

    add4_core u_core (
        .a4 (a_nib),
        .b4 (b_nib),
        .ci (carry_q),
        .s4 (s_nib),
        .co (co_nib)
    );

    // Datapath: capture operands on accept, then write one result nibble per
    // RUN cycle and ripple the carry through carry_q.
    // NOTE: the operand registers are reset along with the visible outputs;
    // they are small flops, not a memory array, so the reset costs nothing
    // and keeps the block fully deterministic after an abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_load;
            idx_q   <= '0;
            carry_q <= carry_load;
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < NIB; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    sum_q[k*NIBBLE +: NIBBLE] <= s_nib;
                end
            end
            carry_q <= co_nib;
            if (last_nib) begin
                idx_q   <= '0;
                c_out_q <= co_nib;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule : nibble_add_seq

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq (WIDTH=16).
// Define NIBBLE_SEQ_SUB_EN for both RTL and bench to exercise subtraction.
module tb_nibble_add_seq;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef NIBBLE_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int checks = 0;
    int errors = 0;
    logic overlap_seen = 1'b0;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef NIBBLE_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clock = ~clock;

    // done and busy must never be high together.
    always @(negedge clock) begin
        if (done && busy) overlap_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and let the next rising edge accept it; afterwards the
    // input buses are scrambled to show the operands were captured.
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic sv);
        a     = av;
        b     = bv;
        c_in  = cv;
`ifdef NIBBLE_SEQ_SUB_EN
        sub   = sv;
`else
        if (sv) $display("note: sub requested but feature not built");
`endif
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        c_in  = 1'b1;
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
    endtask

    // Step edges until done appears (bounded); report edges taken and cycles
    // busy was high, counting the cycle right after the accepting edge.
    task automatic wait_done(input string tag, output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
            if (busy) busy_cycles++;
        end
        if (!done) check({tag, "_timeout"}, done, 1);
    endtask

    int edges;
    int bcyc;
    int done_count;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_sum",   sum,   0);
        check("rst_c_out", c_out, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 3 + 4: basic latency and busy width.
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done("t1", edges, bcyc);
        check("t1_edges", edges, 4);
        check("t1_busy_cycles", bcyc, 4);
        check("t1_busy_in_done", busy, 0);
        check("t1_sum", sum, 16'h0007);
        check("t1_c_out", c_out, 0);
        @(posedge clock);
        #1;
        check("t1_done_pulse", done, 0);
        check("t1_idle_busy", busy, 0);
        @(negedge clock);

        // FFFF + 1: carry ripples through every nibble.
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done("t2", edges, bcyc);
        check("t2_sum", sum, 16'h0000);
        check("t2_c_out", c_out, 1);
        @(negedge clock);

        // Reset mid-cycle after the second nibble edge of an operation.
        launch(16'h0777, 16'h0111, 1'b0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("t3_partial_sum", sum, 16'h0088);
        #3;
        reset = 1'b1;
        #1;
        check("t3_abort_busy",  busy,  0);
        check("t3_abort_done",  done,  0);
        check("t3_abort_sum",   sum,   0);
        check("t3_abort_c_out", c_out, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        launch(16'h1234, 16'h0F0F, 1'b1, 1'b0);
        wait_done("t3b", edges, bcyc);
        check("t3b_edges", edges, 4);
        check("t3b_sum", sum, 16'h2144);
        check("t3b_c_out", c_out, 0);
        @(negedge clock);

        // 9999 + 9999 + 1, then a back-to-back request held in the DONE cycle.
        launch(16'h9999, 16'h9999, 1'b1, 1'b0);
        wait_done("t4", edges, bcyc);
        check("t4_sum", sum, 16'h3333);
        check("t4_c_out", c_out, 1);
        launch(16'h000A, 16'h0005, 1'b0, 1'b0);
        wait_done("t4b", edges, bcyc);
        check("t4b_edges", edges, 4);
        check("t4b_sum", sum, 16'h000F);
        check("t4b_c_out", c_out, 0);
        @(negedge clock);

        // A start pulse during RUN must be ignored.
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        a     = 16'h1111;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_count++;
                check("t5_sum", sum, 16'h5555);
                check("t5_c_out", c_out, 0);
            end
            @(posedge clock);
            #1;
        end
        check("t5_done_count", done_count, 1);
        @(negedge clock);

`ifdef NIBBLE_SEQ_SUB_EN
        // Subtraction: 5 - 7 borrows, 7 - 5 does not.
        launch(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done("t6", edges, bcyc);
        check("t6_sum", sum, 16'hFFFE);
        check("t6_c_out", c_out, 0);
        @(negedge clock);
        launch(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_done("t6b", edges, bcyc);
        check("t6b_sum", sum, 16'h0002);
        check("t6b_c_out", c_out, 1);
        @(negedge clock);
`endif

        check("done_busy_overlap", overlap_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_add_seq
